// File: rtl/fifo_sample_reader.sv
// Read-side consumer for the FIR sample FIFO: credit-based rd_en, 2-entry skid buffer, framed valid/ready output.
// Optional UNDERRUN_STATS_EN adds a saturating underrun_cnt output.
module fifo_sample_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  run,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] FIFO_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  sample_last
`ifdef UNDERRUN_STATS_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  pop;
  logic                  push;
  logic [2:0]            credit;

  assign sample_valid = (occ_q != 2'd0);
  assign sample_out   = head_q;
  assign sample_last  = sample_valid && (frame_cnt_q == FRAME_LAST);

  always_comb begin
    pop         = sample_valid && sample_ready;
    push        = inflight_q;
    // Slots that will be committed after this cycle; a new read is allowed only if one stays free.
    credit      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en       = run && !empty && (credit <= 3'd1);
    inflight_d  = rd_en;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    frame_cnt_d = frame_cnt_q;

    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = FIFO_out;
        else               tail_d = FIFO_out;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = FIFO_out;
        end else begin
          head_d = FIFO_out;
        end
      end
      default: ;
    endcase

    if (pop) frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef UNDERRUN_STATS_EN
  logic [15:0] underrun_q, underrun_d;

  assign underrun_cnt = underrun_q;

  always_comb begin
    underrun_d = underrun_q;
    if (run && sample_ready && !sample_valid && (underrun_q != 16'hFFFF))
      underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) underrun_q <= 16'd0;
    else       underrun_q <= underrun_d;
  end
`endif

endmodule

// File: doc/fifo_sample_reader.md
# fifo_sample_reader

Read-side consumer for the 16-bit sample FIFO feeding the 64-tap FIR. It watches `empty`, issues `rd_en` with credit control that accounts for the FIFO's one-cycle registered output, and buffers returned words in a 2-entry skid buffer. It presents samples on a valid/ready stream to the FIR datapath and marks every FRAME_LEN-th sample with `sample_last`. It sits in the FIFO's read clock domain; `clk` is the same clock as the FIFO's `clk_rd`.

## Interface
- DATA_WIDTH, 16, sample width; matches FIFO DATA_WIDTH.
- FRAME_LEN, 64, samples per frame (FIR tap count); must be ≥2.
- clk  in  1  single clock; rising edge; same clock as FIFO `clk_rd`.
- rstn  in  1  reset; asynchronous, active-low; same net as FIFO `rstn`.
- run  in  1  permit new FIFO reads; in-flight and buffered words still drain when low.
- empty  in  1  FIFO empty flag.
- FIFO_out  in  DATA_WIDTH  FIFO registered read data.
- rd_en  out  1  FIFO read strobe; combinational.
- sample_out  out  DATA_WIDTH  head-of-buffer sample.
- sample_valid  out  1  `sample_out` is valid.
- sample_ready  in  1  downstream accepts.
- sample_last  out  1  current `sample_out` is the last sample of its frame; qualified by `sample_valid`.
- underrun_cnt  out  16  present only with UNDERRUN_STATS_EN.

## Operation
- State:
  - `occ` is buffer occupancy, 0..2.
  - `inflight` is a 1-bit register equal to the previous cycle's `rd_en`.
  - `frame_cnt` is 0..FRAME_LEN-1, width $clog2(FRAME_LEN).
- `pop` = `sample_valid` && `sample_ready`.
- `rd_en` = `run` && !`empty` && (`occ` + `inflight` − `pop`) ≤ 1.
  - Because `rd_en` is gated by !`empty`, every `rd_en` pulse yields exactly one new word on `FIFO_out` in the next cycle.
- Capture: when `inflight` = 1, `FIFO_out` is written at the buffer tail in that cycle. A push and a pop in the same cycle leave `occ` unchanged.
- `sample_valid` = (`occ` ≠ 0). `sample_out` is the buffer head. Order is strictly FIFO order; no word is lost or duplicated.
- Buffer overflow is impossible by construction. The bench asserts `occ` ≤ 2 at all times.
- Frame counting:
  - `frame_cnt` increments on each `pop` and wraps from FRAME_LEN-1 to 0.
  - `sample_last` = `sample_valid` && (`frame_cnt` == FRAME_LEN-1).
- When `run` falls, `rd_en` goes low in the same cycle. An already in-flight word is still captured and delivered. `frame_cnt` is not cleared.
- Reset mid-operation: all state clears asynchronously and any in-flight or buffered word is discarded. The FIFO resets on the same `rstn`.

## Timing
- Reset values:
  - `rd_en` = 0, `sample_valid` = 0, `sample_out` = 0, `sample_last` = 0.
  - `occ` = 0, `inflight` = 0, `frame_cnt` = 0, `underrun_cnt` = 0.
- Latency: `rd_en` high in cycle N → word on `FIFO_out` in N+1 → captured at the end of N+1 → `sample_valid` high in N+2.
- Throughput: with `sample_ready` held at 1 and the FIFO non-empty, one sample is transferred per cycle in steady state.
- Backpressure: with `sample_ready` = 0, at most 2 reads are outstanding or buffered. `rd_en` stays low once `occ` + `inflight` = 2.
- `sample_out`, `sample_valid` and `sample_last` are stable while `sample_valid` && !`sample_ready`.
- `sample_ready` → `rd_en` is a combinational path, and the only such path.

## Configuration
- UNDERRUN_STATS_EN:
  - Defined: `underrun_cnt` is a 16-bit output. It increments every cycle with `run` = 1, `sample_ready` = 1 and `sample_valid` = 0. It saturates at 0xFFFF and clears only on reset.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset: assert `rstn` = 0 mid-stream with `occ` = 2 → all outputs 0 immediately. After release, the first sample delivered is the first word written to the FIFO after reset.
- Streaming: FIFO preloaded with 0x0001..0x0004, `run` = 1, `sample_ready` = 1 → `rd_en` high for 4 consecutive cycles. `sample_valid` rises 2 cycles after the first `rd_en`, and 0x0001..0x0004 transfer on 4 consecutive cycles.
- Backpressure: same preload with `sample_ready` = 0 → exactly 2 `rd_en` pulses, `occ` = 2, `sample_out` = 0x0001 held stable. Releasing `sample_ready` then delivers 0x0001..0x0004 with no gap beyond the pipeline latency.
- Framing: FRAME_LEN = 4, stream 8 samples → `sample_last` high on transfers 4 and 8 only.
- Run gating: drop `run` in the same cycle as an `rd_en` → `rd_en` goes low that cycle. The in-flight word is still delivered, and no further reads occur until `run` = 1.
- Stats, with UNDERRUN_STATS_EN defined: `empty` = 1, `run` = 1, `sample_ready` = 1 for 10 cycles → `underrun_cnt` = 10. With the macro undefined, the port is absent and the scenarios above give identical results.
